// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM state and forward-select encodings for the hazard controller.
//   state_t        : RUN / LOAD_STALL / MEM_WAIT
//   FWD_*          : 2-bit EX operand mux selects
//   fwd_pick()     : EX/MEM beats MEM/WB beats register file
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        return ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_addr_cmp.sv
// hazard_addr_cmp: register address match that never fires on register 0.
//   i_a, i_b : addresses to compare
//   o_match  : 1 when i_a == i_b and the address is nonzero
module hazard_addr_cmp #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_match
);
    assign o_match = (i_a == i_b) && (|i_a);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline.
//   inputs : ID sources (id_rs/rt_addr, id_rs/rt_used), EX destination (ex_rd_addr,
//            ex_reg_wr_ena, ex_mem_rd), MEM destination (mem_rd_addr, mem_reg_wr_ena),
//            branch_taken, mem_stall_req
//   outputs: stage enables (pc/if_id/id_ex_wr_ena), if_id_flush, id_ex_bubble,
//            registered forward selects fwd_a/b_sel, saturating stall_cnt
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_reg_wr_ena,
    input  logic                      ex_mem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_reg_wr_ena,
    input  logic                      branch_taken,
    input  logic                      mem_stall_req,
    output logic                      pc_wr_ena,
    output logic                      if_id_wr_ena,
    output logic                      id_ex_wr_ena,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_fwd_a;
    logic [1:0]           r_fwd_b;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 w_rs_ex;
    logic                 w_rt_ex;
    logic                 w_rs_mem;
    logic                 w_rt_mem;
    logic                 w_load_use;
    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;

    hazard_addr_cmp #(.W(REG_ADDR_WIDTH)) u_cmp_rs_ex  (.i_a(id_rs_addr), .i_b(ex_rd_addr),  .o_match(w_rs_ex));
    hazard_addr_cmp #(.W(REG_ADDR_WIDTH)) u_cmp_rt_ex  (.i_a(id_rt_addr), .i_b(ex_rd_addr),  .o_match(w_rt_ex));
    hazard_addr_cmp #(.W(REG_ADDR_WIDTH)) u_cmp_rs_mem (.i_a(id_rs_addr), .i_b(mem_rd_addr), .o_match(w_rs_mem));
    hazard_addr_cmp #(.W(REG_ADDR_WIDTH)) u_cmp_rt_mem (.i_a(id_rt_addr), .i_b(mem_rd_addr), .o_match(w_rt_mem));

    // Comparators already reject register 0, which also covers ex_rd_addr != 0.
    assign w_load_use = ex_mem_rd && ex_reg_wr_ena &&
                        ((id_rs_used && w_rs_ex) || (id_rt_used && w_rt_ex));

    // A load result is not ready in EX/MEM, so only ALU writes forward from EX.
    assign w_fwd_a = fwd_pick(id_rs_used && w_rs_ex && ex_reg_wr_ena && !ex_mem_rd,
                              id_rs_used && w_rs_mem && mem_reg_wr_ena);
    assign w_fwd_b = fwd_pick(id_rt_used && w_rt_ex && ex_reg_wr_ena && !ex_mem_rd,
                              id_rt_used && w_rt_mem && mem_reg_wr_ena);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MEM_WAIT behaves like RUN once mem_stall_req drops, so a pending branch
    // is flushed on the first released cycle. LOAD_STALL ignores the hazard
    // so the stall lasts exactly one cycle.
    always_comb begin
        w_state_nxt  = ST_RUN;
        pc_wr_ena    = 1'b1;
        if_id_wr_ena = 1'b1;
        id_ex_wr_ena = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst_n) begin
            pc_wr_ena    = 1'b0;
            if_id_wr_ena = 1'b0;
            id_ex_wr_ena = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mem_stall_req) begin
            pc_wr_ena    = 1'b0;
            if_id_wr_ena = 1'b0;
            id_ex_wr_ena = 1'b0;
            w_state_nxt  = ST_MEM_WAIT;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_load_use && r_state != ST_LOAD_STALL) begin
            pc_wr_ena    = 1'b0;
            if_id_wr_ena = 1'b0;
            id_ex_bubble = 1'b1;
            w_state_nxt  = ST_LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (id_ex_bubble) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (id_ex_wr_ena) begin
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_wr_ena && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus, per-cycle model compare, literal spot checks.
module tb_pipeline_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr, mem_rd_addr;
    logic          id_rs_used, id_rt_used, ex_reg_wr_ena, ex_mem_rd, mem_reg_wr_ena;
    logic          branch_taken, mem_stall_req;
    logic          pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, if_id_flush, id_ex_bubble;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wr_ena(ex_reg_wr_ena), .ex_mem_rd(ex_mem_rd),
        .mem_rd_addr(mem_rd_addr), .mem_reg_wr_ena(mem_reg_wr_ena),
        .branch_taken(branch_taken), .mem_stall_req(mem_stall_req),
        .pc_wr_ena(pc_wr_ena), .if_id_wr_ena(if_id_wr_ena), .id_ex_wr_ena(id_ex_wr_ena),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the current event (0 none, 1 memory stall, 2 branch, 3 load-use stall)
    // decides the control outputs; a load-use stall is not re-raised right after one.
    logic      m_ld;
    int        m_cnt;
    int        m_fa, m_fb;
    int        ev;
    logic      hz;

    function automatic int src(input logic used, input logic [RW-1:0] a);
        if (!used || a == 0) return 0;
        if (ex_reg_wr_ena && !ex_mem_rd && a == ex_rd_addr) return 1;
        if (mem_reg_wr_ena && a == mem_rd_addr) return 2;
        return 0;
    endfunction

    always_comb begin
        hz = ex_mem_rd && ex_reg_wr_ena && ex_rd_addr != 0 &&
             ((id_rs_used && id_rs_addr == ex_rd_addr) || (id_rt_used && id_rt_addr == ex_rd_addr));
        ev = mem_stall_req ? 1 : branch_taken ? 2 : (hz && !m_ld) ? 3 : 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ld  <= 1'b0;
            m_cnt <= 0;
            m_fa  <= 0;
            m_fb  <= 0;
        end else begin
            m_ld <= (ev == 3);
            if (ev == 1 || ev == 3) m_cnt <= (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
            if (ev == 2 || ev == 3) begin
                m_fa <= 0;
                m_fb <= 0;
            end else if (ev == 0) begin
                m_fa <= src(id_rs_used, id_rs_addr);
                m_fb <= src(id_rt_used, id_rt_addr);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc pc_wr_ena",    pc_wr_ena,    rst_n && (ev == 0 || ev == 2));
        chk("cyc if_id_wr_ena", if_id_wr_ena, rst_n && (ev == 0 || ev == 2));
        chk("cyc id_ex_wr_ena", id_ex_wr_ena, rst_n && ev != 1);
        chk("cyc if_id_flush",  if_id_flush,  rst_n && ev == 2);
        chk("cyc id_ex_bubble", id_ex_bubble, !rst_n || ev == 2 || ev == 3);
        chk("cyc fwd_a_sel",    fwd_a_sel,    m_fa);
        chk("cyc fwd_b_sel",    fwd_b_sel,    m_fb);
        chk("cyc stall_cnt",    stall_cnt,    m_cnt);
    end

    task automatic idle();
        id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
        ex_rd_addr = 0; ex_reg_wr_ena = 0; ex_mem_rd = 0;
        mem_rd_addr = 0; mem_reg_wr_ena = 0;
        branch_taken = 0; mem_stall_req = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic load_use(input logic [RW-1:0] a);
        ex_mem_rd = 1; ex_reg_wr_ena = 1; ex_rd_addr = a;
        id_rs_addr = a; id_rs_used = 1;
    endtask

    initial begin
        idle();
        mid();
        chk("rst pc_wr_ena", pc_wr_ena, 0);
        chk("rst id_ex_wr_ena", id_ex_wr_ena, 0);
        chk("rst id_ex_bubble", id_ex_bubble, 1);
        chk("rst if_id_flush", if_id_flush, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        nxt(); rst_n = 1;
        mid();
        chk("run pc_wr_ena", pc_wr_ena, 1);
        chk("run id_ex_bubble", id_ex_bubble, 0);
        // load-use on rs=5, preceded by an ALU forward from EX
        nxt(); ex_reg_wr_ena = 1; ex_rd_addr = 5; id_rs_addr = 5; id_rs_used = 1;
        nxt(); load_use(5);
        mid();
        chk("lu fwd_a_prev", fwd_a_sel, 1);
        chk("lu pc_wr_ena", pc_wr_ena, 0);
        chk("lu id_ex_bubble", id_ex_bubble, 1);
        chk("lu id_ex_wr_ena", id_ex_wr_ena, 1);
        chk("lu stall_cnt", stall_cnt, 0);
        nxt(); mem_rd_addr = 5; mem_reg_wr_ena = 1; id_rs_addr = 5; id_rs_used = 1;
        mid();
        chk("ls fwd_a_sel", fwd_a_sel, 0);
        chk("ls pc_wr_ena", pc_wr_ena, 1);
        chk("ls stall_cnt", stall_cnt, 1);
        nxt();
        mid();
        chk("reissue fwd_a_sel", fwd_a_sel, 2);
        // EX beats MEM on rt=3
        nxt(); ex_reg_wr_ena = 1; ex_rd_addr = 3; id_rt_addr = 3; id_rt_used = 1;
        mem_rd_addr = 3; mem_reg_wr_ena = 1;
        nxt();
        mid();
        chk("exwin fwd_b_sel", fwd_b_sel, 1);
        chk("exwin fwd_a_sel", fwd_a_sel, 0);
        // branch with simultaneous load-use, then the hazard alone must still stall
        nxt(); branch_taken = 1; load_use(7);
        mid();
        chk("br if_id_flush", if_id_flush, 1);
        chk("br id_ex_bubble", id_ex_bubble, 1);
        chk("br pc_wr_ena", pc_wr_ena, 1);
        nxt(); load_use(7);
        mid();
        chk("br_run pc_wr_ena", pc_wr_ena, 0);
        nxt();
        // memory stall for 4 cycles masks a pending branch
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_stall_req = 1; branch_taken = 1; load_use(9);
            mid();
            chk("mw pc_wr_ena", pc_wr_ena, 0);
            chk("mw if_id_flush", if_id_flush, 0);
        end
        nxt(); branch_taken = 1;
        mid();
        chk("mw_rel if_id_flush", if_id_flush, 1);
        chk("mw_rel pc_wr_ena", pc_wr_ena, 1);
        chk("mw_rel stall_cnt", stall_cnt, 6);
        // reset in the middle of LOAD_STALL
        nxt(); load_use(9);
        nxt(); #2 rst_n = 0; #1;
        chk("arst pc_wr_ena", pc_wr_ena, 0);
        chk("arst id_ex_bubble", id_ex_bubble, 1);
        chk("arst stall_cnt", stall_cnt, 0);
        chk("arst fwd_a_sel", fwd_a_sel, 0);
        nxt(); rst_n = 1; load_use(9);
        mid();
        chk("post_rst pc_wr_ena", pc_wr_ena, 0);
        nxt();
        // register 0 never stalls or forwards
        nxt(); ex_mem_rd = 1; ex_reg_wr_ena = 1; id_rs_used = 1; id_rt_used = 1;
        mem_reg_wr_ena = 1;
        mid();
        chk("r0 pc_wr_ena", pc_wr_ena, 1);
        nxt(); ex_reg_wr_ena = 1; id_rs_used = 1; id_rt_used = 1; mem_reg_wr_ena = 1;
        nxt();
        mid();
        chk("r0 fwd_a_sel", fwd_a_sel, 0);
        chk("r0 fwd_b_sel", fwd_b_sel, 0);
        // saturation: 20 stalled cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            nxt(); mem_stall_req = 1;
        end
        nxt();
        mid();
        chk("sat stall_cnt", stall_cnt, 15);
        nxt(); mem_stall_req = 1;
        nxt();
        mid();
        chk("sat_hold stall_cnt", stall_cnt, 15);
        nxt();
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
